// File: rtl/gemm_desc_writer_if.sv
// gemm_desc_writer_if: descriptor handshake and system-bus interfaces for the GEMM descriptor writer
interface gemm_desc_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] tile_A_addr;
  logic [31:0] tile_B_addr;
  logic [31:0] tile_C_addr;
  logic [31:0] tile_A_stride;
  logic [31:0] tile_B_stride;
  logic        store;
  logic        overwrite;
  logic [4:0]  msize;
  logic [4:0]  ksize;
  logic [4:0]  nsize;
  modport master (
    output desc_valid, tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride, tile_B_stride,
    output store, overwrite, msize, ksize, nsize,
    input  desc_ready
  );
  modport slave (
    input  desc_valid, tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride, tile_B_stride,
    input  store, overwrite, msize, ksize, nsize,
    output desc_ready
  );
endinterface

interface gemm_bus_if;
  logic        system_bus_en;
  logic        system_bus_rdwr;
  logic [31:0] system_bus_addr;
  logic [31:0] system_bus_wr_data;
  logic [31:0] system_bus_rd_data;
  modport master (
    output system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data,
    input  system_bus_rd_data
  );
  modport slave (
    input  system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data,
    output system_bus_rd_data
  );
endinterface

// File: rtl/gemm_desc_writer.sv
// gemm_desc_writer: polls tile_A buffer status, then writes one descriptor into the GEMM register window
module gemm_desc_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  gemm_desc_if.slave  desc,
  gemm_bus_if.master  bus,
  output logic        o_stalled,
  output logic        o_done,
  output logic [15:0] o_desc_count
);
  typedef enum logic [3:0] {IDLE, POLL, GAP, WR0, WR1, WR2, WR3, WR4, WR5, WR6} state_t;
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);
  state_t      r_state;
  logic [7:0]  r_gap;
  logic        r_ready, r_en, r_rdwr, r_stalled, r_done;
  logic [31:0] r_addr, r_wdata;
  logic [15:0] r_desc_count;
  logic [31:0] r_a, r_b, r_c, r_sa, r_sb;
  logic        r_store, r_ovw;
  logic [4:0]  r_m, r_k, r_n;
  logic        w_accept, w_full, w_unused;
  logic [2:0]  w_idx;
  logic [31:0] w_field, w_waddr;
  assign w_accept = desc.desc_valid && r_ready;
  assign w_full   = bus.system_bus_rd_data[0];
  assign w_unused = ^bus.system_bus_rd_data[31:1];
  // index of the register write issued next cycle (POLL leads into WR0)
  assign w_idx   = (r_state == POLL) ? 3'd0 : 3'(r_state - WR0 + 4'd1);
  assign w_waddr = BASE_ADDR + {27'b0, w_idx, 2'b00};
  assign w_field = (w_idx == 3'd0) ? r_a :
                   (w_idx == 3'd1) ? r_b :
                   (w_idx == 3'd2) ? r_c :
                   (w_idx == 3'd3) ? r_sa :
                   (w_idx == 3'd4) ? r_sb :
                   (w_idx == 3'd5) ? {30'b0, r_ovw, r_store} :
                                     {17'b0, r_n, r_k, r_m};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_gap        <= '0;
      r_ready      <= 1'b0;
      r_en         <= 1'b0;
      r_rdwr       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_stalled    <= 1'b0;
      r_done       <= 1'b0;
      r_desc_count <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_sa         <= '0;
      r_sb         <= '0;
      r_store      <= 1'b0;
      r_ovw        <= 1'b0;
      r_m          <= '0;
      r_k          <= '0;
      r_n          <= '0;
    end else begin
      r_en      <= 1'b0;
      r_rdwr    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_stalled <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          // also acts as the out-of-reset flag: ready rises on the first edge after reset
          r_ready <= !w_accept;
          if (w_accept) begin
            r_a     <= desc.tile_A_addr;
            r_b     <= desc.tile_B_addr;
            r_c     <= desc.tile_C_addr;
            r_sa    <= desc.tile_A_stride;
            r_sb    <= desc.tile_B_stride;
            r_store <= desc.store;
            r_ovw   <= desc.overwrite;
            r_m     <= desc.msize;
            r_k     <= desc.ksize;
            r_n     <= desc.nsize;
            r_state <= POLL;
            r_en    <= 1'b1;
            r_addr  <= BASE_ADDR;
          end
        end
        POLL: begin
          if (w_full) begin
            r_state   <= GAP;
            r_gap     <= GAP_LOAD;
            r_stalled <= 1'b1;
          end else begin
            r_state <= WR0;
            r_en    <= 1'b1;
            r_rdwr  <= 1'b1;
            r_addr  <= w_waddr;
            r_wdata <= w_field;
          end
        end
        GAP: begin
          if (r_gap <= 8'd1) begin
            r_state <= POLL;
            r_gap   <= '0;
            r_en    <= 1'b1;
            r_addr  <= BASE_ADDR;
          end else begin
            r_gap     <= r_gap - 8'd1;
            r_stalled <= 1'b1;
          end
        end
        WR6: begin
          r_state      <= IDLE;
          r_ready      <= 1'b1;
          r_done       <= 1'b1;
          r_desc_count <= r_desc_count + 16'd1;
        end
        default: begin
          r_state <= state_t'(r_state + 4'd1);
          r_en    <= 1'b1;
          r_rdwr  <= 1'b1;
          r_addr  <= w_waddr;
          r_wdata <= w_field;
        end
      endcase
    end
  end
  assign desc.desc_ready      = r_ready;
  assign bus.system_bus_en      = r_en;
  assign bus.system_bus_rdwr    = r_rdwr;
  assign bus.system_bus_addr    = r_addr;
  assign bus.system_bus_wr_data = r_wdata;
  assign o_stalled    = r_stalled;
  assign o_done       = r_done;
  assign o_desc_count = r_desc_count;
endmodule

// File: tb/tb_gemm_desc_writer.sv
// tb_gemm_desc_writer: randomized self-checking bench comparing every bus cycle against a timeline model
module tb_gemm_desc_writer;
  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int GAP = 4;
  typedef struct packed {
    logic        en;
    logic        rdwr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        stall;
    logic        done;
    logic        ready;
    logic [15:0] cnt;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic o_stalled, o_done;
  logic [15:0] o_desc_count;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int poll_cnt = 0;
  int poll_base = 0;
  int nfull_cfg = 0;
  logic [31:0] upper = '0;
  logic [15:0] exp_count = '0;
  gemm_desc_if dif();
  gemm_bus_if  bif();
  gemm_desc_writer #(.BASE_ADDR(BASE), .POLL_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .desc(dif), .bus(bif),
    .o_stalled(o_stalled), .o_done(o_done), .o_desc_count(o_desc_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif.system_bus_en && !bif.system_bus_rdwr) poll_cnt <= poll_cnt + 1;
  end
  // responder: reports full for the first nfull_cfg polls of the current descriptor
  assign bif.system_bus_rd_data = {upper[31:1], (poll_cnt - poll_base) < nfull_cfg};
  function automatic obs_t sample();
    return {bif.system_bus_en, bif.system_bus_rdwr, bif.system_bus_addr, bif.system_bus_wr_data,
            o_stalled, o_done, dif.desc_ready, o_desc_count};
  endfunction
  task automatic report(input string name, input obs_t got, input obs_t exp);
    $display("FAIL %s: got en=%b rw=%b addr=%h data=%h stall=%b done=%b rdy=%b cnt=%h, expected en=%b rw=%b addr=%h data=%h stall=%b done=%b rdy=%b cnt=%h",
             name, got.en, got.rdwr, got.addr, got.data, got.stall, got.done, got.ready, got.cnt,
             exp.en, exp.rdwr, exp.addr, exp.data, exp.stall, exp.done, exp.ready, exp.cnt);
  endtask
  task automatic drive_desc(input logic [31:0] a, b, c, sa, sb, input logic st, ov,
                            input logic [4:0] m, k, n);
    dif.tile_A_addr = a; dif.tile_B_addr = b; dif.tile_C_addr = c;
    dif.tile_A_stride = sa; dif.tile_B_stride = sb;
    dif.store = st; dif.overwrite = ov;
    dif.msize = m; dif.ksize = k; dif.nsize = n;
  endtask
  task automatic drive_random();
    drive_desc($urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask
  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_desc(input string name, input logic [31:0] a, b, c, sa, sb, input logic st, ov,
                          input logic [4:0] m, k, n, input int nfull, input logic [31:0] up,
                          input bit hold, output int t_acc, output int done_off);
    obs_t q[$];
    logic [31:0] f[7];
    obs_t got;
    int w;
    f = '{a, b, c, sa, sb, {30'b0, ov, st}, {17'b0, n, k, m}};
    for (int p = 0; p <= nfull; p++) begin
      q.push_back('{1'b1, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0, exp_count});
      if (p < nfull)
        for (int g = 0; g < (GAP > 0 ? GAP : 1); g++)
          q.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, exp_count});
    end
    for (int i = 0; i < 7; i++)
      q.push_back('{1'b1, 1'b1, BASE + 32'(4 * i), f[i], 1'b0, 1'b0, 1'b0, exp_count});
    q.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, exp_count + 16'd1});
    nfull_cfg = nfull;
    upper = up;
    poll_base = poll_cnt;
    done_off = -1;
    drive_desc(a, b, c, sa, sb, st, ov, m, k, n);
    dif.desc_valid = 1'b1;
    w = 0;
    while (dif.desc_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    t_acc = cyc;
    if (w == 50) begin
      tests++; fails++;
      $display("FAIL %s accept: desc_ready never rose within 50 cycles", name);
      dif.desc_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) begin
      dif.desc_valid = 1'b0;
      drive_random();
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clk);
      got = sample();
      tests++;
      if (got !== q[i]) begin
        fails++;
        report($sformatf("%s T+%0d", name, i + 1), got, q[i]);
      end
      if (got.done === 1'b1 && done_off < 0) done_off = i + 1;
    end
    exp_count = exp_count + 16'd1;
  endtask
  task automatic test_reset();
    obs_t got;
    dif.desc_valid = 1'b0;
    drive_random();
    #2 rst_n = 1'b0;
    #10;
    got = sample();
    tests++;
    if (got !== obs_t'(0)) begin fails++; report("reset_state", got, obs_t'(0)); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (dif.desc_ready !== 1'b0) begin fails++; $display("FAIL ready_at_release: got %b expected 0", dif.desc_ready); end
    @(negedge clk);
    tests++;
    if (dif.desc_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b expected 1", dif.desc_ready); end
    exp_count = '0;
  endtask
  task automatic test_single();
    int t, d;
    run_desc("single", 32'h1000, 32'h2000, 32'h3000, 32'h40, 32'h80, 1'b1, 1'b0, 5'd4, 5'd8, 5'd16,
             0, 32'h0, 1'b0, t, d);
    tests++;
    if (d !== 9) begin fails++; $display("FAIL single_done_offset: got %0d expected 9", d); end
    tests++;
    if (o_desc_count !== 16'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", o_desc_count); end
  endtask
  task automatic test_backoff();
    int t, d;
    run_desc("backoff", 32'hA0, 32'hB0, 32'hC0, 32'h10, 32'h20, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3,
             3, 32'h0, 1'b0, t, d);
    tests++;
    if (d !== 24) begin fails++; $display("FAIL backoff_done_offset: got %0d expected 24", d); end
  endtask
  task automatic test_upper_bits();
    int t, d;
    run_desc("upper_bits", $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b1, 5'd31, 5'd0, 5'd31,
             0, 32'hFFFF_FFFE, 1'b0, t, d);
    tests++;
    if (d !== 9) begin fails++; $display("FAIL upper_bits_done_offset: got %0d expected 9", d); end
  endtask
  task automatic test_back_to_back();
    int t1, t2, d;
    logic [15:0] c0;
    c0 = exp_count;
    run_desc("b2b_first", 32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 1'b1, 1'b1, 5'd5, 5'd6, 5'd7,
             0, 32'h0, 1'b1, t1, d);
    run_desc("b2b_second", 32'h66, 32'h77, 32'h88, 32'h99, 32'hAA, 1'b0, 1'b0, 5'd9, 5'd10, 5'd11,
             0, 32'h0, 1'b1, t2, d);
    dif.desc_valid = 1'b0;
    tests++;
    if (t2 - t1 !== 9) begin fails++; $display("FAIL b2b_spacing: got %0d expected 9", t2 - t1); end
    tests++;
    if (o_desc_count !== c0 + 16'd2) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", o_desc_count, c0 + 16'd2); end
  endtask
  task automatic test_random();
    int t, d;
    bit hold, prev_hold;
    prev_hold = 1'b0;
    for (int r = 0; r < 24; r++) begin
      if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      hold = 1'($urandom);
      run_desc($sformatf("random%0d", r), $urandom, $urandom, $urandom, $urandom, $urandom,
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom & 32'hFFFF_FFFE, hold, t, d);
      prev_hold = hold;
    end
    dif.desc_valid = 1'b0;
  endtask
  task automatic test_reset_mid();
    obs_t got, exp;
    logic [31:0] sa;
    int w, bad;
    nfull_cfg = 0;
    upper = '0;
    poll_base = poll_cnt;
    sa = $urandom;
    drive_desc($urandom, $urandom, $urandom, sa, $urandom, 1'b1, 1'b0, 5'd3, 5'd3, 5'd3);
    dif.desc_valid = 1'b1;
    w = 0;
    while (dif.desc_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    dif.desc_valid = 1'b0;
    repeat (4) @(negedge clk);
    got = sample();
    exp = '{1'b1, 1'b1, BASE + 32'd12, sa, 1'b0, 1'b0, 1'b0, exp_count};
    tests++;
    if (got !== exp) begin fails++; report("mid_wr3", got, exp); end
    rst_n = 1'b0;
    #1;
    got = sample();
    tests++;
    if (got !== obs_t'(0)) begin fails++; report("mid_reset_state", got, obs_t'(0)); end
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (dif.desc_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_after_edge: got %b expected 1", dif.desc_ready); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bif.system_bus_en !== 1'b0 || o_done !== 1'b0 || o_desc_count !== 16'd0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL mid_no_activity: got %0d active cycles expected 0", bad); end
  endtask
  task automatic test_wrap();
    int t, d;
    force dut.r_desc_count = 16'hFFFF;
    #1 release dut.r_desc_count;
    exp_count = 16'hFFFF;
    tests++;
    if (o_desc_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h expected ffff", o_desc_count); end
    @(negedge clk);
    run_desc("wrap", $urandom, $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b1, 5'd2, 5'd4, 5'd6,
             1, 32'h0, 1'b0, t, d);
    tests++;
    if (o_desc_count !== 16'h0000) begin fails++; $display("FAIL wrap_count: got %h expected 0000", o_desc_count); end
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_backoff();
    test_upper_bits();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gemm_desc_writer.md
# gemm_desc_writer

System-bus initiator that programs the GEMM memory-mapped configuration registers on behalf of a descriptor source, such as a host sequencer or DMA command queue. It accepts one tile descriptor per valid/ready handshake. Before writing, it polls the tile_A_addr buffer-full status so that no configuration FIFO overflows. It then issues the seven register writes in fixed order, with tile_dimension last, so the GEMM side's conf_empty falls only after a complete descriptor is present.

## Interface
- BASE_ADDR, 32'h9000_0000, base of the GEMM register window
- POLL_GAP, 4, idle cycles between consecutive status polls while the buffer reports full (range 0-255)

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- desc_valid  in  1  descriptor present
- desc_ready  out  1  writer can accept a descriptor
- tile_A_addr, tile_B_addr, tile_C_addr  in  32 each  descriptor tile base addresses
- tile_A_stride, tile_B_stride  in  32 each  descriptor strides
- store, overwrite  in  1 each  GEMM control bits
- msize, ksize, nsize  in  5 each  tile dimensions
- system_bus_en  out  1  bus transfer valid this cycle
- system_bus_rdwr  out  1  1 = write, 0 = read
- system_bus_addr  out  32  transfer address
- system_bus_wr_data  out  32  write data
- system_bus_rd_data  in  32  read data, valid combinationally in the same cycle as the read
- stalled  out  1  high while waiting out a poll gap because the buffer is full
- done  out  1  one-cycle pulse after the last write of a descriptor
- desc_count  out  16  completed descriptors, wraps modulo 2^16

## Operation
- The descriptor is latched into internal registers on the handshake (desc_valid && desc_ready). Input fields are don't-care after the handshake.
- The GEMM_control word is {30'b0, overwrite, store}.
- The tile_dimension word is {17'b0, nsize, ksize, msize}.
- State machine states: IDLE, POLL, GAP, WR0 to WR6.
- IDLE:
  - desc_ready = 1.
  - On handshake, go to POLL.
- POLL:
  - Drive en=1, rdwr=0, addr=BASE_ADDR, wr_data=0.
  - Sample system_bus_rd_data[0] at the cycle end; bits [31:1] are ignored.
  - If bit 0 = 1 (buffer full), go to GAP and load the gap counter with POLL_GAP.
  - If bit 0 = 0, go to WR0.
- GAP:
  - Bus idle (en=0); stalled=1.
  - Decrement the gap counter and return to POLL when it reaches zero.
  - With POLL_GAP=0, GAP lasts 1 cycle.
- WRi (i = 0..6):
  - Drive en=1, rdwr=1, addr=BASE_ADDR+4*i.
  - Data order: tile_A_addr, tile_B_addr, tile_C_addr, tile_A_stride, tile_B_stride, GEMM_control, tile_dimension.
  - Each write completes in one cycle; the responder applies no backpressure.
  - WR6 goes to IDLE.
- On entering IDLE from WR6: done=1 for that one cycle, and desc_count increments.
- When the bus is idle (en=0), addr, wr_data and rdwr are driven 0.
- Bus outputs and desc_ready decode only from registers. There is no combinational path from any input to any output.
- Only the tile_A buffer status is polled. All seven buffers are written as a group, so their occupancy is identical.

## Timing
- Reset (rst=0) takes effect immediately and asynchronously:
  - state = IDLE, gap counter = 0, desc_count = 0.
  - All bus outputs = 0; done = 0, stalled = 0.
  - desc_ready = 0; a registered out-of-reset flag raises it on the first clk edge after rst rises.
- Accept in cycle T.
  - With no stall: POLL at T+1, WR0 to WR6 at T+2 to T+8, IDLE with done=1 at T+9.
  - A second descriptor can be accepted at T+9, giving a 9-cycle back-to-back throughput.
- Each full-status poll adds 1+max(POLL_GAP,1) cycles before WR0.
- Reset mid-descriptor abandons the descriptor: no further writes, and desc_count is not incremented. The GEMM register block shares rst, so its partial buffer contents are cleared with it.
- desc_valid asserted during non-IDLE states is ignored, because desc_ready=0.

## Test plan
- Single descriptor, rd_data=0:
  - Input: A=0x1000, B=0x2000, C=0x3000, strides 0x40/0x80, store=1, overwrite=0, m=4, k=8, n=16.
  - Expected: one read at 0x9000_0000, then writes at 0x9000_0000 to 0x9000_0018 with data 0x1000, 0x2000, 0x3000, 0x40, 0x80, 0x1, 0x4104 on consecutive cycles; done at T+9; desc_count=1.
- Full back-off:
  - Input: rd_data[0]=1 for the first 3 polls, POLL_GAP=4.
  - Expected: reads at T+1, T+6, T+11, T+16; stalled high only during the gap cycles; WR0 at T+17; done at T+24.
- Upper status bits ignored: rd_data=0xFFFF_FFFE → no stall, WR0 at T+2.
- Back-to-back: desc_valid held high with two descriptors (store=1/overwrite=1, then store=0/overwrite=0) → second handshake at T+9; GEMM_control writes of 0x3 then 0x0; desc_count=2.
- Reset during WR3:
  - Bus en=0 in the same cycle as reset, with no WR4 to WR6; desc_count=0; no done pulse.
  - desc_ready=1 one clk after rst rises.
- Wrap: preload desc_count to 0xFFFF by running 65,535 descriptors (or use a fast-forward force), then complete one more → desc_count=0x0000.
